// File: rtl/sram_1rw_bitmask_pkg.sv
// Shared definitions for the single-port bit-masked SRAM model.
// This file decodes the active-low strobes into one access kind per cycle.
package sram_1rw_bitmask_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    // CEB gates everything; WEB matters only while the chip is enabled.
    function automatic op_e decode_op(input logic ceb, input logic web);
        if (ceb)
            return OP_IDLE;
        else if (web)
            return OP_READ;
        else
            return OP_WRITE;
    endfunction

endpackage

// File: rtl/sram_1rw_bitmask_en_reg_ar.sv
// Parameterised-width register with a load enable and an asynchronous
// active-low clear. It holds the registered read word of the SRAM model.
module en_reg_ar #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/sram_1rw_bitmask.sv
// Behavioural single-port 1RW SRAM with per-bit write mask and registered Q.
// A write cycle returns the merged post-write word, so the read and write paths share one merge.
module sram_1rw_bitmask
    import sram_1rw_bitmask_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             CEB,
    input  logic             WEB,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] BWEB,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] mem [DEPTH];

    op_e              op;
    logic             q_load;
    logic             wr_commit;
    logic [WIDTH-1:0] eff_mask;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] merged_word;

    assign op        = decode_op(CEB, WEB);
    assign q_load    = (op != OP_IDLE);
    assign wr_commit = reset_n && (op == OP_WRITE);

    // Reads behave as a fully masked write, so one merge covers read data and write-through.
    assign eff_mask    = (op == OP_WRITE) ? BWEB : '1;
    assign old_word    = mem[A];
    assign merged_word = (old_word & eff_mask) | (D & ~eff_mask);

    // NOTE: the array has no reset; its contents survive reset_n and stay X until written.
    always_ff @(posedge clk) begin
        if (wr_commit)
            mem[A] <= merged_word;
    end

    en_reg_ar #(
        .W (WIDTH)
    ) u_q_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (q_load),
        .d     (merged_word),
        .q     (Q)
    );

endmodule

// File: tb/tb_sram_1rw_bitmask.sv
// Directed self-checking bench for sram_1rw_bitmask in its 64x128, 64x22 and 64x44 shapes.
// All three instances share the strobes; each scenario checks only the instance it targets.
module tb_sram_1rw_bitmask;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ceb;
    logic         web;
    logic [5:0]   a;
    logic [127:0] d;
    logic [127:0] bweb;
    logic [127:0] q128;
    logic [21:0]  q22;
    logic [43:0]  q44;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [127:0] FULL_DATA = 128'h0123456789ABCDEF_FEDCBA9876543210;

    always #5 clk = ~clk;

    sram_1rw_bitmask #(.DEPTH(64), .WIDTH(128)) u_dut128 (
        .clk (clk), .reset_n (reset_n), .CEB (ceb), .WEB (web),
        .A (a), .D (d), .BWEB (bweb), .Q (q128)
    );

    sram_1rw_bitmask #(.DEPTH(64), .WIDTH(22)) u_dut22 (
        .clk (clk), .reset_n (reset_n), .CEB (ceb), .WEB (web),
        .A (a), .D (d[21:0]), .BWEB (bweb[21:0]), .Q (q22)
    );

    sram_1rw_bitmask #(.DEPTH(64), .WIDTH(44)) u_dut44 (
        .clk (clk), .reset_n (reset_n), .CEB (ceb), .WEB (web),
        .A (a), .D (d[43:0]), .BWEB (bweb[43:0]), .Q (q44)
    );

    // Applies one access across the edge and leaves the bench 1 time unit after it.
    task automatic access(input logic ceb_i, input logic web_i, input logic [5:0] a_i,
                          input logic [127:0] d_i, input logic [127:0] bweb_i);
        ceb  = ceb_i;
        web  = web_i;
        a    = a_i;
        d    = d_i;
        bweb = bweb_i;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [43:0] sweep_word(input int i);
        logic [21:0] v;
        v = 22'(i);
        return {v, ~v};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        access(1'b1, 1'b1, 6'd0, '0, '1);
        access(1'b1, 1'b1, 6'd0, '0, '1);
        reset_n = 1'b1;
        access(1'b0, 1'b0, 6'd7, '0, '0);
        #2 reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, (i == 1), 6'd7, '1, '0);
            vectors += 3;
            if (q128 !== '0) begin miscompares++; $display("FAIL reset_q128[%0d]: got %h want 0", i, q128); end
            if (q22 !== '0)  begin miscompares++; $display("FAIL reset_q22[%0d]: got %h want 0", i, q22); end
            if (q44 !== '0)  begin miscompares++; $display("FAIL reset_q44[%0d]: got %h want 0", i, q44); end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, 6'd7, '1, '0);
            vectors += 3;
            if (q128 !== '0) begin miscompares++; $display("FAIL idle_q128[%0d]: got %h want 0", i, q128); end
            if (q22 !== '0)  begin miscompares++; $display("FAIL idle_q22[%0d]: got %h want 0", i, q22); end
            if (q44 !== '0)  begin miscompares++; $display("FAIL idle_q44[%0d]: got %h want 0", i, q44); end
        end
        access(1'b0, 1'b1, 6'd7, '1, '1);
        vectors += 3;
        if (q128 !== '0) begin miscompares++; $display("FAIL no_write_q128: got %h want 0", q128); end
        if (q22 !== '0)  begin miscompares++; $display("FAIL no_write_q22: got %h want 0", q22); end
        if (q44 !== '0)  begin miscompares++; $display("FAIL no_write_q44: got %h want 0", q44); end
    endtask

    task automatic test_full_write_read();
        access(1'b0, 1'b0, 6'd5, FULL_DATA, '0);
        vectors++;
        if (q128 !== FULL_DATA) begin miscompares++; $display("FAIL full_write_thru: got %h want %h", q128, FULL_DATA); end
        access(1'b0, 1'b1, 6'd5, '0, '1);
        vectors++;
        if (q128 !== FULL_DATA) begin miscompares++; $display("FAIL full_read_a5: got %h want %h", q128, FULL_DATA); end
        access(1'b0, 1'b0, 6'd6, '0, '0);
        access(1'b0, 1'b1, 6'd6, '1, '0);
        vectors++;
        if (q128 !== '0) begin miscompares++; $display("FAIL full_read_a6: got %h want 0", q128); end
        access(1'b0, 1'b1, 6'd5, '0, '0);
        vectors++;
        if (q128 !== FULL_DATA) begin miscompares++; $display("FAIL full_reread_a5: got %h want %h", q128, FULL_DATA); end
    endtask

    task automatic test_bit_mask();
        access(1'b0, 1'b0, 6'd63, {106'h0, 22'h3FFFFF}, '0);
        vectors++;
        if (q22 !== 22'h3FFFFF) begin miscompares++; $display("FAIL mask_fill: got %h want 3fffff", q22); end
        access(1'b0, 1'b0, 6'd63, '0, {106'h0, 22'h3FFF00});
        vectors++;
        if (q22 !== 22'h3FFF00) begin miscompares++; $display("FAIL mask_low_byte_wr: got %h want 3fff00", q22); end
        access(1'b0, 1'b1, 6'd63, '1, '0);
        vectors++;
        if (q22 !== 22'h3FFF00) begin miscompares++; $display("FAIL mask_low_byte_rd: got %h want 3fff00", q22); end
        access(1'b0, 1'b0, 6'd63, '0, {106'h0, 22'h00FFFF});
        vectors++;
        if (q22 !== 22'h00FF00) begin miscompares++; $display("FAIL mask_top_bits_wr: got %h want 00ff00", q22); end
        access(1'b0, 1'b1, 6'd63, '0, '0);
        vectors++;
        if (q22 !== 22'h00FF00) begin miscompares++; $display("FAIL mask_top_bits_rd: got %h want 00ff00", q22); end
        access(1'b0, 1'b0, 6'd63, '0, {106'h0, 22'h3FFFFF});
        vectors++;
        if (q22 !== 22'h00FF00) begin miscompares++; $display("FAIL mask_all_ones_wr: got %h want 00ff00", q22); end
        access(1'b0, 1'b1, 6'd63, '1, '0);
        vectors++;
        if (q22 !== 22'h00FF00) begin miscompares++; $display("FAIL mask_all_ones_rd: got %h want 00ff00", q22); end
    endtask

    task automatic test_chip_disable();
        access(1'b0, 1'b0, 6'd10, {106'h0, 22'h123456}, '0);
        access(1'b0, 1'b1, 6'd10, '0, '0);
        vectors++;
        if (q22 !== 22'h123456) begin miscompares++; $display("FAIL cd_read: got %h want 123456", q22); end
        for (int i = 0; i < 2; i++) begin
            access(1'b1, 1'b0, 6'd10, '0, '0);
            vectors++;
            if (q22 !== 22'h123456) begin miscompares++; $display("FAIL cd_hold[%0d]: got %h want 123456", i, q22); end
        end
        access(1'b0, 1'b1, 6'd63, '0, '0);
        access(1'b0, 1'b1, 6'd10, '0, '0);
        vectors++;
        if (q22 !== 22'h123456) begin miscompares++; $display("FAIL cd_array_kept: got %h want 123456", q22); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] addr;
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            access(1'b0, 1'b0, addr, {84'h0, sweep_word(i)}, '0);
            vectors++;
            if (q44 !== sweep_word(i)) begin
                miscompares++;
                $display("FAIL sweep_wr[%0d]: got %h want %h", i, q44, sweep_word(i));
            end
        end
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            access(1'b0, 1'b1, addr, '0, '0);
            vectors++;
            if (q44 !== sweep_word(i)) begin
                miscompares++;
                $display("FAIL sweep_rd[%0d]: got %h want %h", i, q44, sweep_word(i));
            end
        end
    endtask

    task automatic test_mid_reset();
        access(1'b0, 1'b0, 6'd5, FULL_DATA, '0);
        access(1'b0, 1'b1, 6'd5, '0, '0);
        vectors++;
        if (q128 !== FULL_DATA) begin miscompares++; $display("FAIL mid_pre_reset: got %h want %h", q128, FULL_DATA); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (q128 !== '0) begin miscompares++; $display("FAIL mid_async_clear: got %h want 0", q128); end
        access(1'b1, 1'b1, 6'd5, '0, '1);
        reset_n = 1'b1;
        access(1'b0, 1'b1, 6'd5, '0, '0);
        vectors++;
        if (q128 !== FULL_DATA) begin miscompares++; $display("FAIL mid_array_kept: got %h want %h", q128, FULL_DATA); end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_bit_mask();
        test_chip_disable();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
